key_schedule_rev: RTL and testbench

//  Sequential AES-128 reverse key schedule for the decryption datapath.

---
 rtl/key_schedule_rev.sv | 189 ++++++++++++++++++
 tb/tb_key_schedule_rev.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/key_schedule_rev.sv
// AES-128 reverse key schedule: loads K[NR] and streams K[NR] .. K[0]
// on a valid/ready interface, deriving each key from the previous one.
// Optional build macro: KEY_REV_ZEROIZE_EN clears the key register and
// round number on the edge that completes the K[0] transfer.
//
// state | meaning
// IDLE  | waiting for start, outputs quiet (rk_valid=0)
// RUN   | presenting K[round_num], stepping back on each transfer

module aes_sbox (
  input  logic [3:0] row,
  input  logic [3:0] col,
  output logic [7:0] sub
);

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse in GF(2^8); zero maps to zero.
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] r;
    sq = a;
    r  = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq = gmul(sq, sq);
      r  = gmul(r, sq);
    end
    return r;
  endfunction

  logic [7:0] b;

  // Inverse followed by the forward affine transform.
  always_comb begin
    b   = ginv({row, col});
    sub = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
            ^ {b[3:0], b[7:4]} ^ 8'h63;
  end

endmodule

module key_schedule_rev #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] last_key,
  output logic         busy,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] round_key,
  output logic [3:0]   round_num,
  output logic         done
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [3:0] NR_L = 4'(NR);

  function automatic logic [7:0] rcon_of(input int n);
    case (n)
      1:       return 8'h01;
      2:       return 8'h02;
      3:       return 8'h04;
      4:       return 8'h08;
      5:       return 8'h10;
      6:       return 8'h20;
      7:       return 8'h40;
      8:       return 8'h80;
      9:       return 8'h1b;
      10:      return 8'h36;
      default: return 8'h01;
    endcase
  endfunction

  state_t       state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [3:0]   num_q, num_d;
  logic [7:0]   rcon_q, rcon_d;
  logic         busy_q, busy_d;
  logic         valid_q, valid_d;
  logic         done_q, done_d;

  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  p0, p1, p2, p3;
  logic [31:0]  rot, sub_w;

  assign w0  = key_q[127:96];
  assign w1  = key_q[95:64];
  assign w2  = key_q[63:32];
  assign w3  = key_q[31:0];
  assign p3  = w3 ^ w2;
  assign p2  = w2 ^ w1;
  assign p1  = w1 ^ w0;
  assign rot = {p3[23:0], p3[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (
      .row (rot[31-8*g -: 4]),
      .col (rot[27-8*g -: 4]),
      .sub (sub_w[31-8*g -: 8])
    );
  end

  assign p0 = w0 ^ sub_w ^ {rcon_q, 24'h0};

  // Next-state and datapath update; rk_valid is only ever a register.
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    num_d   = num_q;
    rcon_d  = rcon_q;
    busy_d  = busy_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          key_d   = last_key;
          num_d   = NR_L;
          rcon_d  = rcon_of(NR);
          busy_d  = 1'b1;
          valid_d = 1'b1;
        end
      end
      RUN: begin
        if (rk_ready) begin
          if (num_q != 4'd0) begin
            key_d  = {p0, p1, p2, p3};
            num_d  = num_q - 4'd1;
            rcon_d = (rcon_q == 8'h1b) ? 8'h80 : {1'b0, rcon_q[7:1]};
          end else begin
            state_d = IDLE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
`ifdef KEY_REV_ZEROIZE_EN
            key_d   = 128'h0;
            num_d   = 4'd0;
`else
            key_d   = key_q;
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      key_q   <= 128'h0;
      num_q   <= 4'd0;
      rcon_q  <= 8'h00;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      num_q   <= num_d;
      rcon_q  <= rcon_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign busy      = busy_q;
  assign rk_valid  = valid_q;
  assign round_key = key_q;
  assign round_num = num_q;
  assign done      = done_q;

endmodule

// File: tb/tb_key_schedule_rev.sv
// Directed bench for key_schedule_rev using the FIPS-197 App.A key.
// Honours KEY_REV_ZEROIZE_EN for the post-completion key expectation.

module tb_key_schedule_rev;

  logic         clk;
  logic         rst_n;
  logic         start, start1;
  logic [127:0] last_key, last_key1;
  logic         rk_ready, ready1;
  logic         busy, busy1;
  logic         rk_valid, valid1;
  logic [127:0] round_key, key1;
  logic [3:0]   round_num, num1;
  logic         done, done1;

  int checks = 0;
  int errors = 0;

  logic [127:0] kexp [0:10];
  logic [127:0] kfinal;

  key_schedule_rev #(.NR(10)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .last_key(last_key),
    .busy(busy), .rk_valid(rk_valid), .rk_ready(rk_ready),
    .round_key(round_key), .round_num(round_num), .done(done)
  );

  key_schedule_rev #(.NR(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .last_key(last_key1),
    .busy(busy1), .rk_valid(valid1), .rk_ready(ready1),
    .round_key(key1), .round_num(num1), .done(done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Caller sits just after a negedge. Runs one NR=10 sequence; bp randomises
  // rk_ready, pulse5 pulses start at round 5, stop_at returns early at that
  // round, chain raises start in the done cycle.
  task automatic run10(input bit bp, input bit pulse5, input int stop_at,
                       input bit preloaded, input bit chain);
    int r;
    int cyc;
    r   = 10;
    cyc = 0;
    if (!preloaded) begin
      start    = 1'b1;
      last_key = kexp[10];
    end
    while (r >= 0 && cyc < 500) begin
      @(negedge clk);
      chk("valid", 128'(rk_valid), 128'd1);
      chk("busy", 128'(busy), 128'd1);
      chk("num", 128'(round_num), 128'(r));
      chk("key", round_key, kexp[r]);
      chk("done_low", 128'(done), 128'd0);
      if (r == stop_at) return;
      start    = (pulse5 && r == 5) ? 1'b1 : 1'b0;
      last_key = pulse5 ? 128'hffff_0000_ffff_0000_ffff_0000_ffff_0000 : kexp[10];
      rk_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rk_ready) r--;
      cyc++;
    end
    if (cyc >= 500) chk("timeout", 128'd1, 128'd0);
    @(negedge clk);
    chk("done_pulse", 128'(done), 128'd1);
    chk("busy_end", 128'(busy), 128'd0);
    chk("valid_end", 128'(rk_valid), 128'd0);
    chk("key_end", round_key, kfinal);
    chk("num_end", 128'(round_num), 128'd0);
    start    = chain;
    last_key = kexp[10];
    if (!chain) begin
      @(negedge clk);
      chk("done_once", 128'(done), 128'd0);
      chk("valid_idle", 128'(rk_valid), 128'd0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    kexp[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    kexp[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    kexp[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    kexp[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    kexp[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    kexp[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    kexp[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    kexp[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    kexp[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    kexp[9]  = 128'hac7766f319fadc2128d12941575c006e;
    kexp[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
`ifdef KEY_REV_ZEROIZE_EN
    kfinal = 128'h0;
`else
    kfinal = kexp[0];
`endif

    rst_n = 1'b0; start = 1'b0; last_key = '0; rk_ready = 1'b0;
    start1 = 1'b0; last_key1 = '0; ready1 = 1'b0;
    #12;
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_valid", 128'(rk_valid), 128'd0);
    chk("rst_done", 128'(done), 128'd0);
    chk("rst_num", 128'(round_num), 128'd0);
    chk("rst_key", round_key, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // T1 full speed, chained straight into T2 via start in the done cycle
    run10(1'b0, 1'b0, -1, 1'b0, 1'b1);
    // T2 backpressure
    run10(1'b1, 1'b0, -1, 1'b1, 1'b0);
    // T3 start while busy is ignored
    run10(1'b1, 1'b1, -1, 1'b0, 1'b0);
    // T4 reset at round 7
    run10(1'b0, 1'b0, 7, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 128'(busy), 128'd0);
    chk("arst_valid", 128'(rk_valid), 128'd0);
    chk("arst_done", 128'(done), 128'd0);
    chk("arst_num", 128'(round_num), 128'd0);
    chk("arst_key", round_key, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_valid", 128'(rk_valid), 128'd0);
    chk("post_rst_key", round_key, 128'd0);
    run10(1'b1, 1'b0, -1, 1'b0, 1'b0);

    // T6 NR=1
    start1 = 1'b1; last_key1 = kexp[1]; ready1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    chk("nr1_valid1", 128'(valid1), 128'd1);
    chk("nr1_num1", 128'(num1), 128'd1);
    chk("nr1_key1", key1, kexp[1]);
    @(negedge clk);
    chk("nr1_valid0", 128'(valid1), 128'd1);
    chk("nr1_num0", 128'(num1), 128'd0);
    chk("nr1_key0", key1, kexp[0]);
    @(negedge clk);
    chk("nr1_done", 128'(done1), 128'd1);
    chk("nr1_busy", 128'(busy1), 128'd0);
    chk("nr1_valid_end", 128'(valid1), 128'd0);
    chk("nr1_key_end", key1, kfinal);
    @(negedge clk);
    chk("nr1_done_once", 128'(done1), 128'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
